// File: rtl/dmem_bridge.sv
// Byte-addressable data memory behind a load/store request port with a fixed
// number of wait states per access and sign/zero extension of loads.
module dmem_bridge #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 256,
   parameter int WAIT   = 1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              READ,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] ADDRESS,
   input  logic [1:0]        SIZE,
   input  logic              UNSIGNED,
   input  logic [31:0]       DATA_IN,
   output logic [31:0]       DATA_OUT,
   output logic              READY,
   output logic              BUSY,
   output logic              ERROR
);

   localparam int         IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_RELOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [3:0]        wait_cnt;
   logic [IDX_W-1:0]  cap_idx;
   logic [1:0]        cap_off;
   logic [1:0]        cap_size;
   logic              cap_uns;
   logic              cap_write;
   logic [31:0]       cap_data;
   logic              err_q;

   logic [31:0]       mem [DEPTH];

   logic              req;
   logic              legal;
   logic              accept;

   logic [IDX_W-1:0]  ld_idx;
   logic [1:0]        ld_off;
   logic [1:0]        ld_size;
   logic              ld_uns;
   logic              ld_read;
   logic [31:0]       rd_word;
   logic [31:0]       rd_shift;
   logic [15:0]       rd_half;
   logic [31:0]       ld_val;

   logic [3:0]        wr_be;
   logic [31:0]       wr_lanes;
   logic [31:0]       wr_merged;

   // Request legality
   always_comb begin
      req   = READ | WRITE;
      legal = 1'b1;
      if (READ && WRITE)
         legal = 1'b0;
      case (SIZE)
         2'b01:   if (ADDRESS[0]) legal = 1'b0;
         2'b10:   if (ADDRESS[1:0] != 2'b00) legal = 1'b0;
         2'b11:   legal = 1'b0;
         default: ;
      endcase
      if (32'(ADDRESS >> 2) >= 32'(DEPTH))
         legal = 1'b0;
      accept = (state == ST_IDLE) && req && legal;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      READY     = 1'b0;
      BUSY      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept)
               state_nxt = (WAIT > 0) ? ST_WAIT : ST_DONE;
         end
         ST_WAIT: begin
            BUSY = 1'b1;
            if (wait_cnt == 4'd0)
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            BUSY      = 1'b1;
            READY     = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // With no wait states the load completes on the acceptance edge itself,
   // before the capture registers hold the request, so read from live inputs.
   always_comb begin
      if (state == ST_IDLE) begin
         ld_idx  = ADDRESS[IDX_W+1:2];
         ld_off  = ADDRESS[1:0];
         ld_size = SIZE;
         ld_uns  = UNSIGNED;
         ld_read = READ & ~WRITE;
      end else begin
         ld_idx  = cap_idx;
         ld_off  = cap_off;
         ld_size = cap_size;
         ld_uns  = cap_uns;
         ld_read = ~cap_write;
      end
   end

   always_comb begin
      rd_word  = mem[ld_idx];
      rd_shift = rd_word >> {ld_off, 3'b000};
      rd_half  = ld_off[1] ? rd_word[31:16] : rd_word[15:0];
      case (ld_size)
         2'b00:   ld_val = {{24{~ld_uns & rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   ld_val = {{16{~ld_uns & rd_half[15]}}, rd_half};
         default: ld_val = rd_word;
      endcase
   end

   always_comb begin
      case (cap_size)
         2'b00: begin
            wr_lanes = {4{cap_data[7:0]}};
            wr_be    = 4'b0001 << cap_off;
         end
         2'b01: begin
            wr_lanes = {2{cap_data[15:0]}};
            wr_be    = cap_off[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wr_lanes = cap_data;
            wr_be    = 4'b1111;
         end
      endcase
      wr_merged = mem[cap_idx];
      for (int unsigned i = 0; i < 4; i++)
         if (wr_be[i])
            wr_merged[8*i +: 8] = wr_lanes[8*i +: 8];
   end

   // Store commits on the edge leaving DONE so a reset during DONE aborts it.
   always_ff @(posedge CLK) begin
      if (RESET_N && state == ST_DONE && cap_write)
         mem[cap_idx] <= wr_merged;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wait_cnt  <= '0;
         cap_idx   <= '0;
         cap_off   <= '0;
         cap_size  <= '0;
         cap_uns   <= 1'b0;
         cap_write <= 1'b0;
         cap_data  <= '0;
         err_q     <= 1'b0;
         DATA_OUT  <= '0;
      end else begin
         err_q <= (state == ST_IDLE) && req && !legal;
         if (accept) begin
            wait_cnt  <= WAIT_RELOAD;
            cap_idx   <= ADDRESS[IDX_W+1:2];
            cap_off   <= ADDRESS[1:0];
            cap_size  <= SIZE;
            cap_uns   <= UNSIGNED;
            cap_write <= WRITE;
            cap_data  <= DATA_IN;
         end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (state_nxt == ST_DONE && ld_read)
            DATA_OUT <= ld_val;
      end
   end

   assign ERROR = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: one instance with two wait states, one with
// none; load results are queued when issued and checked at READY.
module tb_dmem_bridge;

   localparam int AW = 10;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          rd   [2];
   logic          wr   [2];
   logic          uns  [2];
   logic [AW-1:0] addr [2];
   logic [1:0]    size [2];
   logic [31:0]   din  [2];
   logic [31:0]   dout [2];
   logic          rdy  [2];
   logic          bsy  [2];
   logic          err  [2];

   int unsigned   lat_exp [2] = '{3, 1};
   logic [31:0]   last_ld [2];
   logic [31:0]   exp_q [$];
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 CLK = ~CLK;

   dmem_bridge #(.ADDR_W(AW), .DEPTH(128), .WAIT(2)) u_w2 (
      .CLK(CLK), .RESET_N(RESET_N), .READ(rd[0]), .WRITE(wr[0]),
      .ADDRESS(addr[0]), .SIZE(size[0]), .UNSIGNED(uns[0]), .DATA_IN(din[0]),
      .DATA_OUT(dout[0]), .READY(rdy[0]), .BUSY(bsy[0]), .ERROR(err[0])
   );

   dmem_bridge #(.ADDR_W(AW), .DEPTH(256), .WAIT(0)) u_w0 (
      .CLK(CLK), .RESET_N(RESET_N), .READ(rd[1]), .WRITE(wr[1]),
      .ADDRESS(addr[1]), .SIZE(size[1]), .UNSIGNED(uns[1]), .DATA_IN(din[1]),
      .DATA_OUT(dout[1]), .READY(rdy[1]), .BUSY(bsy[1]), .ERROR(err[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs(input int i);
      rd[i]   = 1'b0;
      wr[i]   = 1'b0;
      uns[i]  = 1'b0;
      addr[i] = '0;
      size[i] = 2'b00;
      din[i]  = 32'h5A5A_5A5A;
   endtask

   task automatic access(input int i, input string tag, input logic is_wr,
                         input logic [AW-1:0] a, input logic [1:0] sz, input logic u,
                         input logic [31:0] d, input logic [31:0] exp_ld);
      int          n;
      logic [31:0] e;
      @(negedge CLK);
      rd[i]   = ~is_wr;
      wr[i]   = is_wr;
      addr[i] = a;
      size[i] = sz;
      uns[i]  = u;
      din[i]  = d;
      if (!is_wr)
         exp_q.push_back(exp_ld);
      @(posedge CLK);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
         if (n == 1) begin
            check({tag, "_busy"}, 32'(bsy[i]), 32'd1);
            idle_inputs(i);
         end
      end while (!rdy[i] && n < 40);
      check({tag, "_latency"}, n, lat_exp[i]);
      check({tag, "_error"}, 32'(err[i]), 32'd0);
      if (!is_wr) begin
         e = exp_q.pop_front();
         check({tag, "_data"}, dout[i], e);
         last_ld[i] = e;
      end else begin
         check({tag, "_dout_held"}, dout[i], last_ld[i]);
      end
   endtask

   task automatic bad(input int i, input string tag, input logic r, input logic w,
                      input logic [AW-1:0] a, input logic [1:0] sz);
      @(negedge CLK);
      rd[i]   = r;
      wr[i]   = w;
      addr[i] = a;
      size[i] = sz;
      din[i]  = 32'hFFFF_FFFF;
      @(negedge CLK);
      idle_inputs(i);
      check({tag, "_error"}, 32'(err[i]), 32'd1);
      check({tag, "_busy"}, 32'(bsy[i]), 32'd0);
      check({tag, "_ready"}, 32'(rdy[i]), 32'd0);
      check({tag, "_dout"}, dout[i], last_ld[i]);
      @(negedge CLK);
      check({tag, "_error_pulse"}, 32'(err[i]), 32'd0);
      check({tag, "_idle"}, 32'(bsy[i]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs(0);
      idle_inputs(1);
      RESET_N = 1'b0;
      #12;
      for (int i = 0; i < 2; i++) begin
         check("rst_dout", dout[i], 32'd0);
         check("rst_ready", 32'(rdy[i]), 32'd0);
         check("rst_busy", 32'(bsy[i]), 32'd0);
         check("rst_error", 32'(err[i]), 32'd0);
         last_ld[i] = 32'd0;
      end
      @(posedge CLK);
      #2 RESET_N = 1'b1;

      // Two wait states
      access(0, "st_beef", 1'b1, 10'h010, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'd0);
      access(0, "ld_beef", 1'b0, 10'h010, 2'b10, 1'b0, 32'd0, 32'hDEAD_BEEF);
      access(0, "st_word", 1'b1, 10'h010, 2'b10, 1'b0, 32'h1122_3344, 32'd0);
      access(0, "st_byte", 1'b1, 10'h013, 2'b00, 1'b0, 32'hAAAA_AA80, 32'd0);
      access(0, "ld_bs", 1'b0, 10'h013, 2'b00, 1'b0, 32'd0, 32'hFFFF_FF80);
      access(0, "ld_bu", 1'b0, 10'h013, 2'b00, 1'b1, 32'd0, 32'h0000_0080);
      access(0, "ld_word", 1'b0, 10'h010, 2'b10, 1'b1, 32'd0, 32'h8022_3344);

      bad(0, "e_half", 1'b1, 1'b0, 10'h011, 2'b01);
      bad(0, "e_word", 1'b1, 1'b0, 10'h012, 2'b10);
      bad(0, "e_size", 1'b1, 1'b0, 10'h010, 2'b11);
      bad(0, "e_rw", 1'b1, 1'b1, 10'h010, 2'b10);
      bad(0, "e_range", 1'b1, 1'b0, 10'h200, 2'b10);
      bad(0, "e_st_range", 1'b0, 1'b1, 10'h200, 2'b10);

      access(0, "ld_after_err", 1'b0, 10'h010, 2'b10, 1'b0, 32'd0, 32'h8022_3344);
      access(0, "ld_hu", 1'b0, 10'h012, 2'b01, 1'b1, 32'd0, 32'h0000_8022);
      access(0, "st_half", 1'b1, 10'h012, 2'b01, 1'b0, 32'hFFFF_7E55, 32'd0);
      access(0, "ld_half_word", 1'b0, 10'h010, 2'b10, 1'b0, 32'd0, 32'h7E55_3344);

      // No wait states
      access(1, "w0_st", 1'b1, 10'h010, 2'b10, 1'b0, 32'h8001_ABCD, 32'd0);
      access(1, "w0_ld_hs", 1'b0, 10'h012, 2'b01, 1'b0, 32'd0, 32'hFFFF_8001);
      access(1, "w0_ld_hu", 1'b0, 10'h010, 2'b01, 1'b1, 32'd0, 32'h0000_ABCD);
      access(1, "w0_ld_bs", 1'b0, 10'h011, 2'b00, 1'b0, 32'd0, 32'hFFFF_FFAB);

      // Reset in the middle of a store
      access(0, "st_prior", 1'b1, 10'h020, 2'b10, 1'b0, 32'hCAFE_F00D, 32'd0);
      @(negedge CLK);
      rd[0]   = 1'b0;
      wr[0]   = 1'b1;
      addr[0] = 10'h020;
      size[0] = 2'b10;
      din[0]  = 32'h1234_5678;
      @(posedge CLK);
      @(negedge CLK);
      idle_inputs(0);
      check("abort_busy_before", 32'(bsy[0]), 32'd1);
      #1 RESET_N = 1'b0;
      #1;
      check("abort_dout", dout[0], 32'd0);
      check("abort_busy", 32'(bsy[0]), 32'd0);
      check("abort_ready", 32'(rdy[0]), 32'd0);
      check("abort_error", 32'(err[0]), 32'd0);
      check("abort_w0_dout", dout[1], 32'd0);
      repeat (3) @(posedge CLK);
      #1;
      check("abort_held_idle", 32'(bsy[0]), 32'd0);
      #1 RESET_N = 1'b1;
      last_ld[0] = 32'd0;
      last_ld[1] = 32'd0;
      access(0, "ld_prior", 1'b0, 10'h020, 2'b10, 1'b0, 32'd0, 32'hCAFE_F00D);
      access(0, "ld_keep", 1'b0, 10'h010, 2'b10, 1'b0, 32'd0, 32'h7E55_3344);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
